// File: rtl/imem_loader.sv
// Length-prefixed byte stream -> little-endian 32-bit IMEM writes at consecutive addresses; holds the core while loading.
// Latency: word written the cycle after its 4th byte; rx_ready low in WRITE/IDLE/DONE/ERROR, so the source holds the byte.
module imem_loader #(
    parameter int               Width      = 32,
    parameter int               DepthWords = 64,
    parameter logic [Width-1:0] BaseAddr   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             mem_we,
    output logic [Width-1:0] mem_addr,
    output logic [Width-1:0] mem_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [15:0]      words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(DepthWords);

    state_t           state;
    logic [7:0]       len_lo;
    logic             len_phase;
    logic [15:0]      word_len;
    logic [1:0]       byte_cnt;
    logic [Width-1:0] shreg;

    logic             rx_fire;
    logic [15:0]      hdr_len;
    logic [Width-1:0] word_nxt;

    assign rx_fire  = rx_valid && rx_ready;
    assign hdr_len  = {rx_data, len_lo};
    // Each new byte enters at the top, so the first byte ends up in [7:0].
    assign word_nxt = {rx_data, shreg[Width-1:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rx_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= BaseAddr;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            len_lo       <= '0;
            len_phase    <= 1'b0;
            word_len     <= '0;
            byte_cnt     <= '0;
            shreg        <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state        <= S_LEN;
                        rx_ready     <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        len_phase    <= 1'b0;
                        byte_cnt     <= '0;
                    end
                end
                S_LEN: begin
                    if (rx_fire) begin
                        if (!len_phase) begin
                            len_lo    <= rx_data;
                            len_phase <= 1'b1;
                        end else if (hdr_len == 16'd0 || hdr_len > MAX_LEN) begin
                            state    <= S_ERROR;
                            rx_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state    <= S_DATA;
                            word_len <= hdr_len;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_fire) begin
                        shreg    <= word_nxt;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state     <= S_WRITE;
                            rx_ready  <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= BaseAddr + (Width'(words_loaded) << 2);
                            mem_wdata <= word_nxt;
                        end
                    end
                end
                S_WRITE: begin
                    mem_we       <= 1'b0;
                    words_loaded <= words_loaded + 16'd1;
                    if (words_loaded + 16'd1 == word_len) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state    <= S_DATA;
                        rx_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    rx_ready <= 1'b0;
                    mem_we   <= 1'b0;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized load sessions; expected IMEM writes are queued per word and checked by an independent monitor.
module tb_imem_loader;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        reset, start, rx_valid, rx_ready;
    logic [7:0]  rx_data;
    logic        mem_we, cpu_hold, done, error;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    imem_loader #(.Width(32), .DepthWords(DEPTH), .BaseAddr(BASE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] mon_a, mon_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_addr.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
            end else begin
                mon_a = exp_addr.pop_front();
                mon_d = exp_data.pop_front();
                chk("write_addr", mem_addr, mon_a);
                chk("write_data", mem_wdata, mon_d);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // Present one byte; returns at the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit poke);
        int budget;
        int k;
        if (gaps) begin
            k = $urandom_range(0, 3);
            rx_valid = 1'b0;
            repeat (k) begin
                if (poke && $urandom_range(0, 1) == 1) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        budget   = 0;
        while (rx_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            n_vec++;
            n_fail++;
            $display("FAIL rx_ready_timeout: got rx_ready=%b, expected 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic start_session();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("sess_rx_ready", 32'(rx_ready), 32'd1);
        chk("sess_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("sess_words_loaded", 32'(words_loaded), 32'd0);
        chk("sess_done", 32'(done), 32'd0);
        chk("sess_error", 32'(error), 32'd0);
    endtask

    task automatic load(input logic [31:0] words[$], input bit gaps, input bit poke);
        int n;
        logic [31:0] w;
        n = words.size();
        start_session();
        send_byte(n[7:0], gaps, poke);
        send_byte(n[15:8], gaps, poke);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back(w);
            for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gaps, poke && (i != n - 1 || b != 3));
        end
        @(negedge clk);
        chk("end_done", 32'(done), 32'd1);
        chk("end_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("end_rx_ready", 32'(rx_ready), 32'd0);
        chk("end_error", 32'(error), 32'd0);
        chk("end_words_loaded", 32'(words_loaded), 32'(n));
        chk("end_pending_writes", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic bad_header(input logic [15:0] n);
        start_session();
        send_byte(n[7:0], 1'b0, 1'b0);
        send_byte(n[15:8], 1'b0, 1'b0);
        chk("err_error", 32'(error), 32'd1);
        chk("err_rx_ready", 32'(rx_ready), 32'd0);
        chk("err_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("err_done", 32'(done), 32'd0);
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        chk("err_still_blocked", 32'(rx_ready), 32'd0);
        chk("err_words_loaded", 32'(words_loaded), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, BASE);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        logic [31:0] ws[$];
        logic [31:0] w0;
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_state("rst");
        reset = 1'b0;
        @(negedge clk);

        ws = '{32'h002081B3, 32'h403202B3};
        load(ws, 1'b0, 1'b0);
        load(ws, 1'b1, 1'b0);

        bad_header(16'd0);
        bad_header(16'd65);

        ws.delete();
        for (int k = 0; k < DEPTH; k++) ws.push_back(32'(k));
        load(ws, 1'b0, 1'b0);
        chk("full_last_addr", mem_addr, BASE + 32'd252);
        chk("full_last_data", mem_wdata, 32'h0000003F);

        for (int s = 0; s < 6; s++) begin
            ws.delete();
            for (int k = 0; k < int'($urandom_range(1, 8)); k++) ws.push_back($urandom);
            load(ws, 1'b1, 1'b1);
        end

        // Reset after one and a half words of a four-word load.
        start_session();
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        w0 = $urandom;
        exp_addr.push_back(BASE);
        exp_data.push_back(w0);
        for (int b = 0; b < 4; b++) send_byte(w0[8*b +: 8], 1'b1, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("midrst");
        reset = 1'b0;
        @(negedge clk);
        ws = '{32'hCAFE0513};
        load(ws, 1'b1, 1'b0);
        chk("post_rst_addr", mem_addr, BASE);

        repeat (3) @(negedge clk);
        chk("final_pending_writes", 32'(exp_addr.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the single-cycle RISC-V core's instruction memory: the write side of the instruction-memory interface, which the core only reads. Accepts a length-prefixed byte stream (e.g. from a UART receiver), assembles little-endian 32-bit instruction words and writes them at consecutive byte addresses (0, 4, 8, …). Holds the core in reset while loading.

## Interface
- Width, 32, instruction/data word width (fixed 32; 4 bytes per word)
- DepthWords, 64, instruction memory capacity in words; maximum legal load length
- BaseAddr, 0, byte address of the first word written
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- start  input  1  begin a load session (sampled in IDLE/DONE/ERROR only)
- rx_data  input  8  stream byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  byte accepted on cycle with rx_valid & rx_ready
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  output  Width  byte address of write, always multiple of 4
- mem_wdata  output  Width  assembled instruction word
- cpu_hold  output  1  core reset/stall request while loading
- done  output  1  level, load completed successfully
- error  output  1  level, illegal length header
- words_loaded  output  16  count of words written this session

## Operation
- States: IDLE, LEN, DATA, WRITE, DONE, ERROR.
- IDLE: start=1 -> LEN; clears byte/word counters, words_loaded, done, error.
- LEN: rx_ready=1; accepts 2 bytes, first = N[7:0], second = N[15:8].
  - After second byte: N==0 or N>DepthWords -> ERROR; else -> DATA.
- DATA: rx_ready=1; accepts bytes into shift register little-endian (1st byte -> [7:0], 4th -> [31:24]); 2-bit byte counter.
  - 4th byte accepted -> WRITE.
- WRITE (one cycle): mem_we=1, mem_addr=BaseAddr+4*i (i = index of word, 0-based), mem_wdata=assembled word; rx_ready=0; words_loaded increments on this edge.
  - i+1==N -> DONE; else -> DATA.
- DONE: done=1; start=1 -> LEN (new session).
- ERROR: error=1; no bytes accepted; start=1 -> LEN.
- start ignored in LEN, DATA, WRITE.
- cpu_hold=1 in LEN, DATA, WRITE, ERROR; 0 in IDLE, DONE.
- mem_addr/mem_wdata registered; hold last written values outside WRITE. mem_addr arithmetic is Width-bit, no wrap possible since N<=DepthWords.
- Bytes arriving with rx_valid while rx_ready=0 are not consumed; source must hold them.

## Timing
- Reset values: rx_ready=0, mem_we=0, mem_addr=BaseAddr, mem_wdata=0, cpu_hold=0, done=0, error=0, words_loaded=0, state IDLE.
- start at edge t -> LEN, rx_ready=1 and cpu_hold=1 from t+1.
- 4th data byte accepted at edge t -> mem_we=1 during cycle t..t+1; rx_ready=0 that cycle; rx_ready=1 again next cycle unless last word.
- Last word's WRITE at edge t -> done=1, cpu_hold=0 from t+1.
- Length byte 2 accepted at edge t with illegal N -> error=1, rx_ready=0 from t+1.
- Max throughput: 4 bytes per 5 cycles.
- reset mid-session: next edge -> IDLE, all outputs to reset values; memory already written is left as is; a WRITE cycle coincident with reset is not performed (mem_we low after the edge).

## Test plan
- Load N=2: bytes 02 00, B3 81 20 00, B3 02 32 40 continuous -> writes 0x002081B3 @0, 0x403202B3 @4; exactly 2 mem_we pulses; done=1, words_loaded=2, cpu_hold falls.
- Backpressure/gaps: same stream with rx_valid toggling randomly, byte held during WRITE -> identical writes, no byte lost or duplicated.
- Illegal length: header 00 00 -> error=1, no mem_we; header 41 00 (65, DepthWords=64) -> error=1, rx_ready=0, cpu_hold=1; then start with valid header recovers.
- Full depth: N=64, word k = k -> last write 0x0000003F @ address 252; done=1.
- Reset mid-load after 1.5 words of N=4 -> IDLE, all outputs reset values; new start loads N=1 correctly @0.
- start pulses during LEN/DATA -> ignored, counters unchanged; start in DONE -> new session with words_loaded cleared.
